// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared constants for the DSP48A1 slice model.
//   P_W / M_W          : post-adder width and multiplier product width.
//   X_* / Z_*          : operand-select codes for OPMODE[1:0] and OPMODE[3:2].
//   OP_CIN / OP_SUB    : OPMODE bit positions of carry-in and subtract.
// ---------------------------------------------------------------------------
package dsp_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;

    // X operand select, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    // Z operand select, OPMODE[3:2]
    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    // OPMODE bit indices
    localparam int OP_CIN = 5;
    localparam int OP_SUB = 7;

    // Sign-extend the multiplier product to the post-adder width.
    function automatic logic signed [P_W-1:0] sext_m(input logic signed [M_W-1:0] m);
        return {{(P_W - M_W){m[M_W-1]}}, m};
    endfunction

endpackage

// File: rtl/dsp_xz_mux.sv
// ---------------------------------------------------------------------------
// dsp_xz_mux
// Combinational X / Z operand selection for the post-adder.
// Ports:
//   x_sel  in  [1:0]      X select (OPMODE[1:0])
//   z_sel  in  [1:0]      Z select (OPMODE[3:2])
//   m_in   in  [M_W-1:0]  signed multiplier product (sign-extended on X)
//   p_fb   in  [P_W-1:0]  P feedback from the internal P register
//   dab_in in  [P_W-1:0]  {D[11:0], A[17:0], B[17:0]}
//   pcin   in  [P_W-1:0]  cascade input
//   c_in   in  [P_W-1:0]  C operand
//   x_op   out [P_W-1:0]  selected X operand
//   z_op   out [P_W-1:0]  selected Z operand
// ---------------------------------------------------------------------------
module dsp_xz_mux
    import dsp_pkg::*;
(
    input  logic [1:0]            x_sel,
    input  logic [1:0]            z_sel,
    input  logic signed [M_W-1:0] m_in,
    input  logic [P_W-1:0]        p_fb,
    input  logic [P_W-1:0]        dab_in,
    input  logic [P_W-1:0]        pcin,
    input  logic [P_W-1:0]        c_in,
    output logic [P_W-1:0]        x_op,
    output logic [P_W-1:0]        z_op
);

    always_comb begin
        x_op = '0;
        unique case (x_sel)
            X_ZERO:  x_op = '0;
            X_M:     x_op = sext_m(m_in);
            X_P:     x_op = p_fb;
            X_DAB:   x_op = dab_in;
            default: x_op = '0;
        endcase
    end

    always_comb begin
        z_op = '0;
        unique case (z_sel)
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = pcin;
            Z_P:     z_op = p_fb;
            Z_C:     z_op = c_in;
            default: z_op = '0;
        endcase
    end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// ---------------------------------------------------------------------------
// dsp_post_adder_acc
// Post-adder / accumulator stage of the DSP48A1 slice model.
// Computes P = Z +/- (X + cin) modulo 2^48 with a 49th carry/borrow bit.
// Parameters:
//   PREG  1 = p/pcout registered (latency 1), 0 = combinational (latency 0)
//   P_W   post-adder width, 48 for DSP48A1 compatibility
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (P and carry registers)
//   ce_p       in   clock enable for P and carry registers
//   opmode     in   [1:0] X sel, [3:2] Z sel, [5] cin, [7] subtract
//   m_in       in   36-bit signed multiplier product
//   c_in       in   C operand
//   pcin       in   cascade input
//   dab_in     in   {D, A, B}
//   p          out  post-adder result
//   pcout      out  cascade copy of p
//   carryout   out  carry (add) / borrow (subtract)
//   carryoutf  out  fabric copy of carryout
// Configuration macro: DSP_CARRYOUT_REG_EN
//   defined   -> carry outputs come from a register loaded with ce_p
//   undefined -> carry outputs are combinational from the adder
// ---------------------------------------------------------------------------
module dsp_post_adder_acc #(
    parameter int PREG = 1,
    parameter int P_W  = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce_p,
    input  logic [7:0]                     opmode,
    input  logic signed [dsp_pkg::M_W-1:0] m_in,
    input  logic [P_W-1:0]                 c_in,
    input  logic [P_W-1:0]                 pcin,
    input  logic [P_W-1:0]                 dab_in,
    output logic [P_W-1:0]                 p,
    output logic [P_W-1:0]                 pcout,
    output logic                           carryout,
    output logic                           carryoutf
);

    import dsp_pkg::*;

    logic [P_W-1:0] p_q;
    logic [P_W-1:0] p_d;
    logic [P_W-1:0] x_op;
    logic [P_W-1:0] z_op;
    logic [P_W:0]   sum;
    logic           cin;
    logic           sub;
    logic           carry_comb;

    // OPMODE[4] and OPMODE[6] have no function in this slice.
    logic unused_opmode_bits;
    assign unused_opmode_bits = ^{opmode[6], opmode[4]};

    assign cin = opmode[OP_CIN];
    assign sub = opmode[OP_SUB];

    dsp_xz_mux u_xz_mux (
        .x_sel  (opmode[1:0]),
        .z_sel  (opmode[3:2]),
        .m_in   (m_in),
        .p_fb   (p_q),
        .dab_in (dab_in),
        .pcin   (pcin),
        .c_in   (c_in),
        .x_op   (x_op),
        .z_op   (z_op)
    );

    // 49-bit add/subtract; bit P_W is carry on add and borrow on subtract
    // (a negative 49-bit difference wraps and sets the top bit).
    always_comb begin
        sum = '0;
        if (sub) begin
            sum = {1'b0, z_op} - ({1'b0, x_op} + {{P_W{1'b0}}, cin});
        end else begin
            sum = {1'b0, z_op} + {1'b0, x_op} + {{P_W{1'b0}}, cin};
        end
    end

    assign carry_comb = sum[P_W];

    // The feedback register updates on every enabled edge regardless of
    // PREG, so accumulation is identical in both output modes.
    always_comb begin
        p_d = p_q;
        if (ce_p) begin
            p_d = sum[P_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    generate
        if (PREG != 0) begin : g_preg
            assign p = p_q;
        end else begin : g_pcomb
            assign p = sum[P_W-1:0];
        end
    endgenerate

    assign pcout = p;

`ifdef DSP_CARRYOUT_REG_EN
    logic carry_q;
    logic carry_d;

    always_comb begin
        carry_d = carry_q;
        if (ce_p) begin
            carry_d = carry_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carryout  = carry_q;
    assign carryoutf = carry_q;
`else
    // Combinational carry: with PREG=1 this is the carry of the value p
    // will take on the next enabled edge.
    assign carryout  = carry_comb;
    assign carryoutf = carry_comb;
`endif

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// ---------------------------------------------------------------------------
// tb_dsp_post_adder_acc
// Table-driven bench for dsp_post_adder_acc (PREG = 1). Each vector drives
// one clock cycle; its expected P and carry are pushed to a scoreboard queue
// when driven and popped when the registered result appears.
// ---------------------------------------------------------------------------
module tb_dsp_post_adder_acc;

    typedef struct {
        logic         rst;
        logic         ce;
        logic [7:0]   op;
        logic [35:0]  m;
        logic [47:0]  c;
        logic [47:0]  pc;
        logic [47:0]  dab;
        logic [47:0]  exp_p;
        logic         exp_cy;
        logic         chk_cy;
    } vec_t;

    typedef struct {
        logic [47:0] p;
        logic        cy;
        logic        chk_cy;
        logic        after_edge;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce_p;
    logic [7:0]  opmode;
    logic [35:0] m_in;
    logic [47:0] c_in;
    logic [47:0] pcin;
    logic [47:0] dab_in;
    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
    logic        carryoutf;

    int n_cmp;
    int n_bad;
    int vec_idx;
    exp_t sb_q[$];

    dsp_post_adder_acc #(.PREG(1), .P_W(48)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_p      (ce_p),
        .opmode    (opmode),
        .m_in      (m_in),
        .c_in      (c_in),
        .pcin      (pcin),
        .dab_in    (dab_in),
        .p         (p),
        .pcout     (pcout),
        .carryout  (carryout),
        .carryoutf (carryoutf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk48(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_carry(input exp_t e);
        chk1("carryout", e.idx, carryout, e.cy);
        chk1("carryoutf", e.idx, carryoutf, e.cy);
    endtask

    // Drive one vector at the falling edge, then compare after the rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst    = v.rst;
        ce_p   = v.ce;
        opmode = v.op;
        m_in   = v.m;
        c_in   = v.c;
        pcin   = v.pc;
        dab_in = v.dab;
        e.p      = v.exp_p;
        e.cy     = v.exp_cy;
        e.chk_cy = v.chk_cy;
        e.idx    = vec_idx;
`ifdef DSP_CARRYOUT_REG_EN
        e.after_edge = 1'b1;
`else
        // Combinational carry is visible before the edge; on reset rows the
        // feedback is not yet defined, so the carry is checked afterwards.
        e.after_edge = v.rst;
`endif
        sb_q.push_back(e);
        #1;
        if (e.chk_cy && !e.after_edge) check_carry(e);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue expected one entry", vec_idx);
        end else begin
            got = sb_q.pop_front();
            chk48("p", got.idx, p, got.p);
            chk48("pcout", got.idx, pcout, got.p);
            if (got.chk_cy && got.after_edge) check_carry(got);
        end
        vec_idx++;
    endtask

    function automatic vec_t mk(input logic r, input logic ce, input logic [7:0] op,
                                input logic [35:0] m, input logic [47:0] c,
                                input logic [47:0] pc, input logic [47:0] dab,
                                input logic [47:0] ep, input logic ecy, input logic chk);
        vec_t v;
        v.rst = r; v.ce = ce; v.op = op; v.m = m; v.c = c; v.pc = pc; v.dab = dab;
        v.exp_p = ep; v.exp_cy = ecy; v.chk_cy = chk;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        n_cmp   = 0;
        n_bad   = 0;
        vec_idx = 0;
        rst     = 1'b1;
        ce_p    = 1'b1;
        opmode  = 8'h00;
        m_in    = '0;
        c_in    = '0;
        pcin    = '0;
        dab_in  = '0;

        //         rst   ce    op     m                c                   pcin      dab                  exp_p                cy    chk
        // reset with arbitrary operands
        tbl.push_back(mk(1'b1, 1'b1, 8'h09, 36'd123,        48'hDEAD_BEEF_0001, 48'd77,   48'h5555,          48'h0,               1'b0, 1'b1));
        // MAC: X=M, Z=P, m=5 for four cycles, then hold two cycles
        tbl.push_back(mk(1'b0, 1'b1, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd5,               1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd10,              1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd15,              1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd20,              1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd20,              1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 8'h09, 36'd5,          48'h0,              48'h0,    48'h0,             48'd20,              1'b0, 1'b1));
        // negative product sign-extended: X=M, Z=0
        tbl.push_back(mk(1'b0, 1'b1, 8'h01, 36'hF_FFFF_FFFD, 48'h0,             48'h0,    48'h0,             48'hFFFF_FFFF_FFFD,  1'b0, 1'b1));
        // subtract with borrow: C - (DAB + 1) = 3 - 11
        tbl.push_back(mk(1'b0, 1'b1, 8'hAF, 36'd0,          48'd3,              48'h0,    48'd10,            48'hFFFF_FFFF_FFF8,  1'b1, 1'b1));
        // wrap: C all ones + cin
        tbl.push_back(mk(1'b0, 1'b1, 8'h2C, 36'd0,          48'hFFFF_FFFF_FFFF, 48'h0,    48'h0,             48'h0,               1'b1, 1'b1));
        // X=DAB, Z=PCIN
        tbl.push_back(mk(1'b0, 1'b1, 8'h07, 36'd0,          48'h0,              48'd100,  48'h1234,          48'h1298,            1'b0, 1'b1));
        // X=P, Z=C
        tbl.push_back(mk(1'b0, 1'b1, 8'h0E, 36'd0,          48'd7,              48'h0,    48'h0,             48'h129F,            1'b0, 1'b1));
        // X=P, Z=P (doubling)
        tbl.push_back(mk(1'b0, 1'b1, 8'h0A, 36'd0,          48'h0,              48'h0,    48'h0,             48'h253E,            1'b0, 1'b1));
        // P - P = 0, no borrow
        tbl.push_back(mk(1'b0, 1'b1, 8'h8A, 36'd0,          48'h0,              48'h0,    48'h0,             48'h0,               1'b0, 1'b1));
        // 0 - (0 + 1): borrow
        tbl.push_back(mk(1'b0, 1'b1, 8'hA0, 36'd0,          48'h0,              48'h0,    48'h0,             48'hFFFF_FFFF_FFFF,  1'b1, 1'b1));
        // ignored OPMODE bits 4 and 6 set
        tbl.push_back(mk(1'b0, 1'b1, 8'h51, 36'd7,          48'h0,              48'h0,    48'h0,             48'd7,               1'b0, 1'b1));
        // large add with carry out
        tbl.push_back(mk(1'b0, 1'b1, 8'h0F, 36'd0,          48'h8000_0000_0001, 48'h0,    48'h8000_0000_0000, 48'h1,              1'b1, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset mid-MAC: two accumulations, reset on the third cycle, resume.
        apply(mk(1'b1, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'h0,  1'b0, 1'b1));
        apply(mk(1'b0, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'd5,  1'b0, 1'b1));
        apply(mk(1'b0, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'd10, 1'b0, 1'b1));
        apply(mk(1'b1, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'h0,  1'b0, 1'b1));
        apply(mk(1'b0, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'd5,  1'b0, 1'b1));

        // Reset wins even with ce_p low; then a frozen cycle, then accumulate.
        apply(mk(1'b0, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'd10, 1'b0, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'h0,  1'b0, 1'b1));
        apply(mk(1'b0, 1'b0, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'h0,  1'b0, 1'b1));
        apply(mk(1'b0, 1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 48'd5,  1'b0, 1'b1));

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsp_post_adder_acc.md
# dsp_post_adder_acc

Post-adder / accumulator stage of the DSP48A1 slice model. It takes the registered multiplier product M, the C operand, the cascade input PCIN and the concatenated D:A:B word from the input register/mux stages. It selects X and Z operands per OPMODE, adds or subtracts them with carry-in, and produces the P result, PCOUT cascade and carry outputs. An optional P register enables multiply-accumulate.

## Interface
- `PREG`, default 1: 1 = P and PCOUT registered; 0 = combinational P path (no accumulation storage beyond the feedback register).
- `P_W`, default 48: post-adder / P width; fixed at 48 for DSP48A1 compatibility.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high; clears P and carry registers.
- `ce_p` input, 1 bit: clock enable for P and carry registers.
- `opmode` input, 8 bits: [1:0] X select, [3:2] Z select, [5] carry-in, [7] subtract; bits [4] and [6] are ignored.
- `m_in` input, 36 bits: signed multiplier product.
- `c_in` input, 48 bits: C operand.
- `pcin` input, 48 bits: cascade input from the neighbouring slice.
- `dab_in` input, 48 bits: {D[11:0], A[17:0], B[17:0]}.
- `p` output, 48 bits: post-adder result.
- `pcout` output, 48 bits: identical copy of `p` for cascade.
- `carryout` output, 1 bit: post-adder carry/borrow.
- `carryoutf` output, 1 bit: fabric copy of `carryout`, identical value.

## Operation
- X mux, `opmode[1:0]`:
  - 0 → zero.
  - 1 → `m_in` sign-extended to 48 bits.
  - 2 → P feedback, the current registered P.
  - 3 → `dab_in`.
- Z mux, `opmode[3:2]`:
  - 0 → zero.
  - 1 → `pcin`.
  - 2 → P feedback.
  - 3 → `c_in`.
- Carry-in `cin` = `opmode[5]`.
- Add (`opmode[7]` = 0): 49-bit sum = {0,Z} + {0,X} + cin; P = sum[47:0]; carry = sum[48].
- Subtract (`opmode[7]` = 1): 49-bit diff = {0,Z} − ({0,X} + cin); P = diff[47:0]; carry = diff[48], where 1 means borrow.
- All arithmetic is modulo 2^48. There is no saturation and no overflow flag.
- P feedback always refers to the internal P register. It holds its value when `ce_p` = 0. When `PREG` = 0, the feedback register still updates each enabled cycle, so accumulation behaviour is identical; only the `p` output timing differs.
- Reset priority: `rst` > `ce_p`. Every register clears to 0.
- Reset values: `p` = 0, `pcout` = 0, `carryout` = 0, `carryoutf` = 0 (combinational outputs reflect the adder of zeroed feedback).

## Timing
- `PREG` = 1: `p`/`pcout` update on the rising edge when `ce_p` = 1, giving latency 1 cycle from operands/opmode.
- `PREG` = 0: `p`/`pcout` = adder output combinationally, latency 0.
- Accumulate (X=1, Z=2): each enabled edge adds the current `m_in`. `ce_p` low for N cycles freezes the accumulator for N cycles.
- OPMODE change takes effect on the next enabled edge. There is no pipeline flush.
- `rst` asserted mid-accumulation: the next edge gives P = 0 regardless of `ce_p`. The first edge after deassert accumulates onto 0.
- Simultaneous `rst` and `ce_p`: reset wins.

## Configuration
- `DSP_CARRYOUT_REG_EN` defined:
  - `carryout`/`carryoutf` come from a carry register loaded with `ce_p` and cleared by `rst`.
  - The carry is cycle-aligned with `p` when `PREG` = 1.
- Not defined:
  - `carryout`/`carryoutf` are combinational from the current adder output.
  - With `PREG` = 1, the carry is therefore the carry of the next pending P value, one cycle ahead of `p`.

## Structure
- Shared package `dsp_pkg`:
  - `P_W`, `M_W`.
  - Localparams `X_ZERO`, `X_M`, `X_P`, `X_DAB`, `Z_ZERO`, `Z_PCIN`, `Z_P`, `Z_C`.
  - OPMODE bit indices: `OP_CIN` = 5, `OP_SUB` = 7.
- Sub-module `dsp_xz_mux`: combinational X/Z operand select, including sign extension of M.
- The top module holds the adder, P register and carry register.

## Test plan
- Reset: drive `rst` = 1 with `ce_p` = 1 and arbitrary operands → after the edge, `p` = 0, `pcout` = 0, `carryout` = 0.
- MAC: `opmode` = 0x09 (X=M, Z=P), `m_in` = 5 for 4 enabled cycles from reset → `p` = 5, 10, 15, 20; `ce_p` = 0 for 2 cycles → `p` holds at 20.
- Negative product: `m_in` = 36'hF_FFFF_FFFD (−3), X=M, Z=0 → `p` = 48'hFFFF_FFFF_FFFD.
- Subtract with borrow: X=DAB = 10, Z=C = 3, `opmode[7]` = 1, `cin` = 1 → `p` = 48'hFFFF_FFFF_FFF8; `carryout` = 1 (registered if `DSP_CARRYOUT_REG_EN`, one cycle earlier otherwise).
- Wrap: `c_in` = 48'hFFFF_FFFF_FFFF, X=0, `cin` = 1 → `p` = 0, `carryout` = 1.
- Reset mid-MAC: assert `rst` on cycle 3 of the MAC sequence → `p` = 0; the next enabled cycle gives `p` = 5.
